// File: rtl/vote_result_reporter.sv
// vote_result_reporter: on each rising edge of mode, snapshots the four
// candidate counters and sends them as a 6-byte 8N1 UART frame:
// HEADER, count1, count2, count3, count4, xor-checksum.
module vote_result_reporter #(
   parameter int unsigned CLKS_PER_BIT = 8,
   parameter logic [7:0]  HEADER       = 8'hA5
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       mode,
   input  logic [7:0] count1,
   input  logic [7:0] count2,
   input  logic [7:0] count3,
   input  logic [7:0] count4,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam int unsigned TW_RAW    = $clog2(CLKS_PER_BIT + 1);
   localparam int unsigned TW        = (TW_RAW < 1) ? 1 : TW_RAW;
   localparam logic [TW-1:0] T_LAST  = TW'(CLKS_PER_BIT - 1);
   localparam logic [2:0] LAST_BYTE  = 3'd5;
   localparam logic [2:0] LAST_BIT   = 3'd7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t        state;
   logic          mode_q;
   logic [TW-1:0] timer;
   logic [2:0]    byte_idx;
   logic [2:0]    bit_idx;
   logic [7:0]    snap1;
   logic [7:0]    snap2;
   logic [7:0]    snap3;
   logic [7:0]    snap4;
   logic [7:0]    checksum;

   logic          req;
   logic          bit_end;
   logic [2:0]    next_bit;
   logic [7:0]    cur_byte;

   // Rising-edge request and end-of-bit-period strobe
   assign req      = mode & ~mode_q;
   assign bit_end  = (timer == T_LAST);
   assign next_bit = bit_idx + 3'd1;

   // Byte currently being serialised, selected by byte index
   always_comb begin
      cur_byte = HEADER;
      case (byte_idx)
         3'd0:    cur_byte = HEADER;
         3'd1:    cur_byte = snap1;
         3'd2:    cur_byte = snap2;
         3'd3:    cur_byte = snap3;
         3'd4:    cur_byte = snap4;
         3'd5:    cur_byte = checksum;
         default: cur_byte = HEADER;
      endcase
   end

   // Frame sequencer: edge detect, snapshot, bit timing and registered outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         mode_q   <= 1'b0;
         timer    <= '0;
         byte_idx <= 3'd0;
         bit_idx  <= 3'd0;
         snap1    <= 8'd0;
         snap2    <= 8'd0;
         snap3    <= 8'd0;
         snap4    <= 8'd0;
         checksum <= 8'd0;
         tx       <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         mode_q <= mode;
         done   <= 1'b0;
         case (state)
            IDLE: begin
               tx    <= 1'b1;
               busy  <= 1'b0;
               timer <= '0;
               if (req) begin
                  snap1    <= count1;
                  snap2    <= count2;
                  snap3    <= count3;
                  snap4    <= count4;
                  checksum <= count1 ^ count2 ^ count3 ^ count4;
                  byte_idx <= 3'd0;
                  bit_idx  <= 3'd0;
                  tx       <= 1'b0;
                  busy     <= 1'b1;
                  state    <= START;
               end
            end

            START: begin
               if (bit_end) begin
                  timer   <= '0;
                  bit_idx <= 3'd0;
                  tx      <= cur_byte[0];
                  state   <= DATA;
               end else begin
                  timer <= timer + TW'(1);
               end
            end

            DATA: begin
               if (bit_end) begin
                  timer <= '0;
                  if (bit_idx == LAST_BIT) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     bit_idx <= next_bit;
                     tx      <= cur_byte[next_bit];
                  end
               end else begin
                  timer <= timer + TW'(1);
               end
            end

            STOP: begin
               if (bit_end) begin
                  timer <= '0;
                  if (byte_idx < LAST_BYTE) begin
                     byte_idx <= byte_idx + 3'd1;
                     tx       <= 1'b0;
                     state    <= START;
                  end else begin
                     tx    <= 1'b1;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= IDLE;
                  end
               end else begin
                  timer <= timer + TW'(1);
               end
            end

            default: begin
               tx    <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vote_result_reporter.sv
// Bench for vote_result_reporter: two instances (8 and 1 clocks per bit)
// checked every cycle against a frame-level model, plus decoded-byte checks.
module tb_vote_result_reporter;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       mode_s  [2];
   logic [7:0] cnt_s   [2][4];
   logic       tx_s    [2];
   logic       busy_s  [2];
   logic       done_s  [2];

   int checks = 0;
   int errors = 0;

   int cpb_k [2] = '{8, 1};

   always #5 clock = ~clock;

   vote_result_reporter #(.CLKS_PER_BIT(8), .HEADER(8'hA5)) dut8 (
      .clock(clock), .reset(reset), .mode(mode_s[0]),
      .count1(cnt_s[0][0]), .count2(cnt_s[0][1]),
      .count3(cnt_s[0][2]), .count4(cnt_s[0][3]),
      .tx(tx_s[0]), .busy(busy_s[0]), .done(done_s[0])
   );

   vote_result_reporter #(.CLKS_PER_BIT(1), .HEADER(8'hA5)) dut1 (
      .clock(clock), .reset(reset), .mode(mode_s[1]),
      .count1(cnt_s[1][0]), .count2(cnt_s[1][1]),
      .count3(cnt_s[1][2]), .count4(cnt_s[1][3]),
      .tx(tx_s[1]), .busy(busy_s[1]), .done(done_s[1])
   );

   // ---------------- frame-level model ----------------
   logic mprev_m  [2] = '{1'b0, 1'b0};
   logic active_m [2] = '{1'b0, 1'b0};
   int   cnt_m    [2] = '{0, 0};
   logic frame_m  [2][60];
   logic exp_tx   [2] = '{1'b1, 1'b1};
   logic exp_busy [2] = '{1'b0, 1'b0};
   logic exp_done [2] = '{1'b0, 1'b0};
   logic       m_req;
   logic [7:0] m_fb [6];

   // Model advances on the rising edge using inputs driven away from it
   always @(posedge clock) begin
      for (int k = 0; k < 2; k++) begin
         if (!reset) begin
            mprev_m[k]  = 1'b0;
            active_m[k] = 1'b0;
            cnt_m[k]    = 0;
            exp_tx[k]   = 1'b1;
            exp_busy[k] = 1'b0;
            exp_done[k] = 1'b0;
         end else begin
            m_req       = mode_s[k] && !mprev_m[k];
            mprev_m[k]  = mode_s[k];
            exp_done[k] = 1'b0;
            if (active_m[k]) begin
               cnt_m[k] = cnt_m[k] + 1;
               if (cnt_m[k] == 60 * cpb_k[k]) begin
                  active_m[k] = 1'b0;
                  exp_done[k] = 1'b1;
               end
            end else if (m_req) begin
               m_fb[0] = 8'hA5;
               m_fb[1] = cnt_s[k][0];
               m_fb[2] = cnt_s[k][1];
               m_fb[3] = cnt_s[k][2];
               m_fb[4] = cnt_s[k][3];
               m_fb[5] = cnt_s[k][0] ^ cnt_s[k][1] ^ cnt_s[k][2] ^ cnt_s[k][3];
               for (int b = 0; b < 6; b++) begin
                  frame_m[k][b*10] = 1'b0;
                  for (int i = 0; i < 8; i++) frame_m[k][b*10+1+i] = m_fb[b][i];
                  frame_m[k][b*10+9] = 1'b1;
               end
               active_m[k] = 1'b1;
               cnt_m[k]    = 0;
            end
            exp_busy[k] = active_m[k];
            exp_tx[k]   = active_m[k] ? frame_m[k][cnt_m[k] / cpb_k[k]] : 1'b1;
         end
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clock) begin
      for (int k = 0; k < 2; k++) begin
         checks = checks + 1;
         if (tx_s[k] !== exp_tx[k] || busy_s[k] !== exp_busy[k] || done_s[k] !== exp_done[k]) begin
            errors = errors + 1;
            $display("FAIL cycle_model inst%0d t=%0t tx/busy/done got %b%b%b want %b%b%b",
                     k, $time, tx_s[k], busy_s[k], done_s[k], exp_tx[k], exp_busy[k], exp_done[k]);
         end
      end
   end

   // ---------------- line recorder / decoder ----------------
   logic       txrec     [2][480];
   logic       busy_prev [2] = '{1'b0, 1'b0};
   int         blen      [2] = '{0, 0};
   int         last_len  [2] = '{0, 0};
   int         frames    [2] = '{0, 0};
   int         dones     [2] = '{0, 0};
   logic [7:0] rx        [2][6];

   // Record tx while busy; decode bytes at mid-bit once busy drops
   always @(negedge clock) begin
      for (int k = 0; k < 2; k++) begin
         if (busy_s[k] === 1'b1) begin
            if (!busy_prev[k]) frames[k] = frames[k] + 1;
            if (blen[k] < 480) txrec[k][blen[k]] = tx_s[k];
            blen[k] = blen[k] + 1;
         end else if (busy_prev[k]) begin
            last_len[k] = blen[k];
            for (int b = 0; b < 6; b++)
               for (int i = 0; i < 8; i++)
                  rx[k][b][i] = txrec[k][(b*10+1+i)*cpb_k[k] + cpb_k[k]/2];
            blen[k] = 0;
         end
         if (done_s[k] === 1'b1) dones[k] = dones[k] + 1;
         busy_prev[k] = (busy_s[k] === 1'b1);
      end
   end

   // ---------------- helpers ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clock);
         #1;
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         errors = errors + 1;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic wait_idle(input int k);
      for (int i = 0; i < 1000; i++) begin
         if (busy_s[k] !== 1'b1) break;
         tick(1);
      end
      checks = checks + 1;
      if (busy_s[k] !== 1'b0) begin
         errors = errors + 1;
         $display("FAIL wait_idle inst%0d got busy=%b want 0 within 1000 cycles", k, busy_s[k]);
      end
   endtask

   task automatic check_frame(input int k, input string name, input logic [47:0] exp);
      logic [47:0] e;
      e = exp;
      for (int b = 0; b < 6; b++)
         chk($sformatf("%s_byte%0d", name, b), int'(rx[k][b]), int'(e[47-8*b -: 8]));
   endtask

   // ---------------- directed stimulus ----------------
   int f0, f1, d0;

   initial begin
      for (int k = 0; k < 2; k++) begin
         mode_s[k] = 1'b0;
         for (int j = 0; j < 4; j++) cnt_s[k][j] = 8'd0;
      end
      #1 reset = 1'b0;

      // Reset held with mode toggling: outputs stay idle
      for (int i = 0; i < 10; i++) begin
         tick(1);
         mode_s[0] = ~mode_s[0];
         mode_s[1] = ~mode_s[1];
      end
      chk("rst_tx", int'(tx_s[0]), 1);
      chk("rst_busy", int'(busy_s[0]), 0);
      chk("rst_done", int'(done_s[0]), 0);
      mode_s[0] = 1'b0;
      mode_s[1] = 1'b0;
      tick(1);
      reset = 1'b1;
      tick(2);

      // Basic frame 3,1,0,0 with snapshot hold and long mode level
      cnt_s[0][0] = 8'd3; cnt_s[0][1] = 8'd1; cnt_s[0][2] = 8'd0; cnt_s[0][3] = 8'd0;
      f0 = frames[0];
      d0 = dones[0];
      mode_s[0] = 1'b1;
      tick(1);
      chk("basic_latency_busy", int'(busy_s[0]), 1);
      chk("basic_latency_tx", int'(tx_s[0]), 0);
      tick(99);
      cnt_s[0][0] = 8'd7;
      tick(1900);
      chk("level_one_frame", frames[0] - f0, 1);
      check_frame(0, "basic", 48'hA5_03_01_00_00_02);
      chk("basic_busy_len", last_len[0], 480);
      chk("basic_done_pulses", dones[0] - d0, 1);

      // New frame, then a mid-frame 1->0->1 toggle that must be ignored
      mode_s[0] = 1'b0;
      tick(2);
      f0 = frames[0];
      mode_s[0] = 1'b1;
      tick(50);
      mode_s[0] = 1'b0;
      tick(2);
      mode_s[0] = 1'b1;
      wait_idle(0);
      chk("toggle_no_extra", frames[0] - f0, 1);
      check_frame(0, "second", 48'hA5_07_01_00_00_06);

      // Toggle after done: frame starts on the request edge
      mode_s[0] = 1'b0;
      tick(1);
      mode_s[0] = 1'b1;
      tick(1);
      chk("rearm_busy", int'(busy_s[0]), 1);
      chk("rearm_tx", int'(tx_s[0]), 0);
      wait_idle(0);
      chk("rearm_frames", frames[0] - f0, 2);

      // One clock per bit, all counters at FF
      for (int j = 0; j < 4; j++) cnt_s[1][j] = 8'hFF;
      f1 = frames[1];
      mode_s[1] = 1'b1;
      tick(1);
      chk("fast_busy", int'(busy_s[1]), 1);
      wait_idle(1);
      check_frame(1, "fast", 48'hA5_FF_FF_FF_FF_00);
      chk("fast_busy_len", last_len[1], 60);
      chk("fast_frames", frames[1] - f1, 1);

      // Reset mid-frame, then release with mode held high
      cnt_s[0][0] = 8'd9; cnt_s[0][1] = 8'd8; cnt_s[0][2] = 8'd7; cnt_s[0][3] = 8'd6;
      mode_s[0] = 1'b0;
      tick(1);
      mode_s[0] = 1'b1;
      tick(30);
      reset = 1'b0;
      #1;
      chk("midrst_tx", int'(tx_s[0]), 1);
      chk("midrst_busy", int'(busy_s[0]), 0);
      tick(3);
      reset = 1'b1;
      tick(1);
      chk("release_busy", int'(busy_s[0]), 1);
      chk("release_tx", int'(tx_s[0]), 0);
      wait_idle(0);
      check_frame(0, "release", 48'hA5_09_08_07_06_00);
      chk("release_busy_len", last_len[0], 480);
      wait_idle(1);
      tick(5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
